// File: rtl/eth_frame_tx.sv
// Ethernet frame transmitter: serializes a latched header (dest, src, type) and
// the payload stream into one byte stream, optionally zero-padding to 60 bytes.
module eth_frame_tx #(
  parameter bit ENABLE_PADDING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_eth_hdr_valid,
  output logic        s_eth_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [7:0]  s_eth_payload_axis_tdata,
  input  logic        s_eth_payload_axis_tvalid,
  output logic        s_eth_payload_axis_tready,
  input  logic        s_eth_payload_axis_tlast,
  input  logic        s_eth_payload_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, PAD} state_t;

  localparam logic [5:0] MIN_LEN = 6'd60;

  state_t       r_state, w_state_nxt;
  logic [47:0]  r_dest, r_src;
  logic [15:0]  r_type;
  logic [5:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic         r_hold_user, w_hold_user_nxt;
  logic         w_slot_free, w_hdr_xfer, w_pay_ready;
  logic         w_load, w_load_last, w_load_user;
  logic [7:0]   w_load_data;
  logic [111:0] w_hdr_vec, w_hdr_shifted;
  logic [3:0]   w_hdr_idx;
  logic [7:0]   w_hdr_byte;

  assign w_slot_free               = !m_axis_tvalid || m_axis_tready;
  assign s_eth_hdr_ready           = (r_state == IDLE);
  assign w_hdr_xfer                = s_eth_hdr_valid && (r_state == IDLE);
  assign s_eth_payload_axis_tready = w_pay_ready;
  assign busy                      = (r_state != IDLE);
  assign w_cnt_inc                 = (r_cnt >= MIN_LEN) ? MIN_LEN : r_cnt + 6'd1;

  // Byte 0 comes straight from the input fields so it can be loaded in the
  // same cycle the header is accepted; later bytes come from the latched copy.
  always_comb begin
    w_hdr_vec     = w_hdr_xfer ? {s_eth_dest_mac, s_eth_src_mac, s_eth_type}
                               : {r_dest, r_src, r_type};
    w_hdr_idx     = w_hdr_xfer ? 4'd0 : r_cnt[3:0];
    w_hdr_shifted = w_hdr_vec << {w_hdr_idx, 3'b000};
    w_hdr_byte    = w_hdr_shifted[111:104];
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hold_user_nxt = r_hold_user;
    w_load          = 1'b0;
    w_load_data     = '0;
    w_load_last     = 1'b0;
    w_load_user     = 1'b0;
    w_pay_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_eth_hdr_valid) begin
          w_state_nxt = HDR;
          w_cnt_nxt   = '0;
          if (w_slot_free) begin
            w_load      = 1'b1;
            w_load_data = w_hdr_byte;
            w_cnt_nxt   = 6'd1;
          end
        end
      end
      HDR: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = w_hdr_byte;
          w_cnt_nxt   = w_cnt_inc;
          if (r_cnt == 6'd13) w_state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        w_pay_ready = w_slot_free;
        if (w_slot_free && s_eth_payload_axis_tvalid) begin
          w_load      = 1'b1;
          w_load_data = s_eth_payload_axis_tdata;
          w_load_user = s_eth_payload_axis_tuser;
          w_cnt_nxt   = w_cnt_inc;
          if (s_eth_payload_axis_tlast) begin
            if (!ENABLE_PADDING || (w_cnt_inc >= MIN_LEN)) begin
              w_load_last = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              // Abort flag travels with the final pad byte instead.
              w_load_user     = 1'b0;
              w_hold_user_nxt = s_eth_payload_axis_tuser;
              w_state_nxt     = PAD;
            end
          end
        end
      end
      PAD: begin
        if (w_slot_free) begin
          w_load    = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= MIN_LEN) begin
            w_load_last = 1'b1;
            w_load_user = r_hold_user;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_hold_user   <= 1'b0;
      r_dest        <= '0;
      r_src         <= '0;
      r_type        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold_user <= w_hold_user_nxt;
      if (w_hdr_xfer) begin
        r_dest <= s_eth_dest_mac;
        r_src  <= s_eth_src_mac;
        r_type <= s_eth_type;
      end
      if (w_slot_free) begin
        m_axis_tvalid <= w_load;
        if (w_load) begin
          m_axis_tdata <= w_load_data;
          m_axis_tlast <= w_load_last;
          m_axis_tuser <= w_load_user;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Scoreboard bench for eth_frame_tx: a frame-level model queues expected bytes,
// an independent monitor pops and compares each accepted output byte.
module tb_eth_frame_tx;

  localparam int unsigned TMO = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        hdr_valid;
  logic [47:0] dest, src;
  logic [15:0] etype;
  logic [7:0]  p_data;
  logic        p_valid, p_last, p_user;
  logic        m_ready;
  logic        rand_ready;

  logic a_hdr_ready, a_p_ready, a_tvalid, a_tlast, a_tuser, a_busy;
  logic b_hdr_ready, b_p_ready, b_tvalid, b_tlast, b_tuser, b_busy;
  logic [7:0] a_tdata, b_tdata;

  eth_frame_tx #(.ENABLE_PADDING(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_eth_hdr_valid(hdr_valid && !sel), .s_eth_hdr_ready(a_hdr_ready),
    .s_eth_dest_mac(dest), .s_eth_src_mac(src), .s_eth_type(etype),
    .s_eth_payload_axis_tdata(p_data), .s_eth_payload_axis_tvalid(p_valid && !sel),
    .s_eth_payload_axis_tready(a_p_ready), .s_eth_payload_axis_tlast(p_last),
    .s_eth_payload_axis_tuser(p_user),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_ready),
    .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser), .busy(a_busy)
  );

  eth_frame_tx #(.ENABLE_PADDING(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n),
    .s_eth_hdr_valid(hdr_valid && sel), .s_eth_hdr_ready(b_hdr_ready),
    .s_eth_dest_mac(dest), .s_eth_src_mac(src), .s_eth_type(etype),
    .s_eth_payload_axis_tdata(p_data), .s_eth_payload_axis_tvalid(p_valid && sel),
    .s_eth_payload_axis_tready(b_p_ready), .s_eth_payload_axis_tlast(p_last),
    .s_eth_payload_axis_tuser(p_user),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(m_ready),
    .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser), .busy(b_busy)
  );

  logic hdr_ready, p_ready, m_tvalid, m_tlast, m_tuser, busy;
  logic [7:0] m_tdata;
  assign hdr_ready = sel ? b_hdr_ready : a_hdr_ready;
  assign p_ready   = sel ? b_p_ready   : a_p_ready;
  assign m_tvalid  = sel ? b_tvalid    : a_tvalid;
  assign m_tlast   = sel ? b_tlast     : a_tlast;
  assign m_tuser   = sel ? b_tuser     : a_tuser;
  assign m_tdata   = sel ? b_tdata     : a_tdata;
  assign busy      = sel ? b_busy      : a_busy;

  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
  beat_t exp_q[$];

  int unsigned checks = 0, failures = 0;
  int unsigned cyc = 0, out_idx = 0;
  bit          gap_mode = 1'b0;
  int          first_cyc = -1, last_cyc = 0, gap_bytes = 0;
  logic        prev_stall = 1'b0;
  beat_t       prev_beat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string what);
    failures++;
    $display("FAIL timeout_%s got=no_event exp=event", what);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench stopped on timeout");
  endtask

  // Monitor: compares accepted output bytes against the model queue.
  always @(negedge clk) begin
    beat_t got, e;
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
      out_idx    = 0;
    end else begin
      got = '{d: m_tdata, l: m_tlast, u: m_tuser};
      if (prev_stall) begin
        checks++;
        if (!(m_tvalid === 1'b1 && got === prev_beat)) begin
          failures++;
          $display("FAIL stall_stable got v=%0b %0h exp v=1 %0h", m_tvalid, got, prev_beat);
        end
      end
      if (m_tvalid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_byte got d=%02h exp=none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL byte[%0d] got d=%02h l=%0b u=%0b exp d=%02h l=%0b u=%0b",
                     out_idx, got.d, got.l, got.u, e.d, e.l, e.u);
          end
        end
        out_idx = got.l ? 0 : out_idx + 1;
      end
      checks++;
      if (hdr_ready !== !busy) begin
        failures++;
        $display("FAIL hdr_ready_vs_busy got=%0b exp=%0b", hdr_ready, !busy);
      end
      if (gap_mode && m_tvalid) begin
        if (first_cyc < 0) first_cyc = int'(cyc);
        last_cyc = int'(cyc);
        gap_bytes++;
      end
      prev_stall = m_tvalid && !m_ready;
      prev_beat  = got;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) m_ready = 1'($urandom % 2);
  end

  // Frame-level reference: header, payload, then zero pad up to 60 bytes when enabled.
  task automatic model_frame(input logic [111:0] hdr, input logic [7:0] pd[$],
                             input logic pu[$], input bit pad);
    int n = pd.size();
    int total = 14 + n;
    bit padded = pad && (total < 60);
    if (padded) total = 60;
    for (int k = 0; k < 14; k++) exp_q.push_back('{d: hdr[111 - 8*k -: 8], l: 1'b0, u: 1'b0});
    for (int i = 0; i < n; i++)
      exp_q.push_back('{d: pd[i], l: (i == n-1) && !padded,
                        u: ((i == n-1) && padded) ? 1'b0 : pu[i]});
    for (int k = 14 + n; k < total; k++)
      exp_q.push_back('{d: 8'h00, l: k == total-1, u: (k == total-1) ? pu[n-1] : 1'b0});
  endtask

  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int n, input bit rnd, input bit gaps, input bit pad,
                            input int abort_at, input bit last_user, input bit chk_lat);
    logic [7:0] pd[$];
    logic       pu[$];
    int unsigned w;
    for (int i = 0; i < n; i++) begin
      pd.push_back(rnd ? 8'($urandom) : 8'(i));
      pu.push_back(rnd ? ($urandom % 8 == 0) : ((i == n-1) && last_user));
    end
    model_frame({d, s, t}, pd, pu, pad);
    dest = d; src = s; etype = t; hdr_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (hdr_ready) break;
      if (++w > TMO) timeout("hdr_ready");
    end
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    if (chk_lat) begin
      chk("hdr_latency_valid", 32'(m_tvalid), 32'd1);
      chk("hdr_latency_byte0", 32'(m_tdata), 32'(d[47:40]));
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom % 3 == 0) begin
        p_valid = 1'b0;
        @(posedge clk); #1;
      end
      p_valid = 1'b1; p_data = pd[i]; p_user = pu[i]; p_last = (i == n-1);
      if (i == abort_at) begin
        rst_n = 1'b0; #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_p_ready", 32'(p_ready), 32'd0);
        exp_q.delete();
        p_valid = 1'b0; p_last = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      w = 0;
      forever begin
        @(negedge clk);
        if (p_ready) break;
        if (++w > TMO) timeout("payload_ready");
      end
      @(posedge clk); #1;
    end
    p_valid = 1'b0; p_last = 1'b0; p_user = 1'b0;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (exp_q.size() != 0 || busy || m_tvalid) begin
      @(negedge clk);
      if (++w > TMO) timeout("drain");
    end
    @(posedge clk); #1;
  endtask

  localparam logic [47:0] MAC_D = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_S = 48'h02_00_00_00_00_02;

  initial begin
    rst_n = 1'b0; sel = 1'b0; hdr_valid = 1'b0; p_valid = 1'b0; p_last = 1'b0;
    p_user = 1'b0; p_data = '0; dest = '0; src = '0; etype = '0;
    m_ready = 1'b1; rand_ready = 1'b0;
    #1;
    chk("reset_tvalid", 32'(a_tvalid), 32'd0);
    chk("reset_tlast", 32'(a_tlast), 32'd0);
    chk("reset_tuser", 32'(a_tuser), 32'd0);
    chk("reset_tdata", 32'(a_tdata), 32'd0);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_p_ready", 32'(a_p_ready), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("hdr_ready_after_reset", 32'(a_hdr_ready), 32'd1);

    // 50-byte IPv4-type frame, 28-byte ARP-type padded frame
    send_frame(MAC_D, MAC_S, 16'h0800, 50, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1);
    drain();
    send_frame(MAC_D, MAC_S, 16'h0806, 28, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b1);
    drain();

    // Same short frame through the non-padding instance
    sel = 1'b1;
    send_frame(MAC_D, MAC_S, 16'h0806, 28, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b1);
    drain();
    sel = 1'b0;

    // Back-to-back frames with no backpressure: output must be gapless
    gap_mode = 1'b1;
    send_frame(MAC_D, MAC_S, 16'h0800, 50, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    send_frame(MAC_D, MAC_S, 16'h0800, 45, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    send_frame(MAC_D, MAC_S, 16'h0800, 46, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    drain();
    gap_mode = 1'b0;
    chk("b2b_byte_count", 32'(gap_bytes), 32'd184);
    chk("b2b_no_gaps", 32'(last_cyc - first_cyc + 1), 32'(gap_bytes));

    // Reset while payload byte 20 is presented, then a clean frame
    send_frame(MAC_D, MAC_S, 16'h0800, 40, 1'b1, 1'b0, 1'b1, 20, 1'b0, 1'b0);
    send_frame(MAC_D, MAC_S, 16'h0800, 30, 1'b1, 1'b0, 1'b1, -1, 1'b1, 1'b1);
    drain();

    // Random lengths, data, tuser, payload gaps and downstream backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 100; f++)
      send_frame(48'({$urandom, $urandom}), 48'({$urandom, $urandom}), 16'($urandom),
                 int'($urandom_range(1, 80)), 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    drain();
    rand_ready = 1'b0;
    m_ready = 1'b1;
    chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/eth_frame_tx.md
ETH_FRAME_TX -- requirements
Module: eth_frame_tx

Interface
REQ-001 SHALL have parameter ENABLE_PADDING, default 1, meaning zero-pad frames shorter than 60 bytes (header + payload) up to 60 bytes.
REQ-002 SHALL have ports, one per line:
  clk  input  1  clock; all logic on rising edge
  rst_n  input  1  reset, asynchronous, active-low
  s_eth_hdr_valid  input  1  header valid
  s_eth_hdr_ready  output  1  header accepted
  s_eth_dest_mac  input  48  destination MAC
  s_eth_src_mac  input  48  source MAC
  s_eth_type  input  16  EtherType
  s_eth_payload_axis_tdata  input  8  payload byte
  s_eth_payload_axis_tvalid  input  1  payload valid
  s_eth_payload_axis_tready  output  1  payload accepted
  s_eth_payload_axis_tlast  input  1  last payload byte
  s_eth_payload_axis_tuser  input  1  frame bad/abort flag
  m_axis_tdata  output  8  frame byte
  m_axis_tvalid  output  1  frame byte valid
  m_axis_tready  input  1  downstream ready
  m_axis_tlast  output  1  last frame byte
  m_axis_tuser  output  1  frame bad/abort flag
  busy  output  1  frame in progress

Function
REQ-003 SHALL serialize one header plus payload into a byte stream: dest MAC, src MAC, type, each most-significant byte first (bytes 0-13), then payload bytes.
REQ-004 SHALL implement states IDLE, HDR, PAYLOAD, PAD.
REQ-005 SHALL drive s_eth_hdr_ready=1 only in IDLE; header transfer (valid&ready) latches all header fields, clears byte counter, moves to HDR.
REQ-006 SHALL register all m_axis_* outputs; an output slot is free when !m_axis_tvalid or m_axis_tready.
REQ-007 SHALL present header byte 0 on m_axis_tdata with m_axis_tvalid=1 in the cycle after header transfer (latency 1).
REQ-008 In HDR SHALL load the next header byte each cycle the slot is free; after byte 13 is loaded, move to PAYLOAD.
REQ-009 In PAYLOAD SHALL assert s_eth_payload_axis_tready = slot free (combinational from m_axis_tready); each accepted byte loads tdata/tuser into the output register.
REQ-010 SHALL keep a 6-bit frame byte counter, saturating at 60, incremented per byte loaded to the output.
REQ-011 On accepted payload tlast: if ENABLE_PADDING=0 or counter after that byte >=60, SHALL set m_axis_tlast=1 and return to IDLE; else SHALL set m_axis_tlast=0, hold tuser value, move to PAD.
REQ-012 In PAD SHALL load 0x00 bytes per free slot; the byte bringing the count to 60 SHALL carry m_axis_tlast=1 and the held tuser, then return to IDLE.
REQ-013 m_axis_tuser SHALL be 0 on all header bytes and on non-final pad bytes.
REQ-014 SHALL hold m_axis_tdata/tlast/tuser stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-015 busy SHALL be 1 in HDR, PAYLOAD, PAD, 0 in IDLE.
REQ-016 Header valid asserted outside IDLE SHALL be ignored (not accepted) until IDLE; the next header may be accepted in the cycle after last-byte load, overlapping the final byte drain.
REQ-017 Payload bytes with tvalid while not in PAYLOAD SHALL be stalled (tready=0), never dropped.

Reset
REQ-018 rst_n low SHALL asynchronously force state IDLE, counter 0, m_axis_tvalid/tlast/tuser 0, m_axis_tdata 0x00, busy 0, s_eth_payload_axis_tready 0; s_eth_hdr_ready SHALL be 1 once rst_n is high.
REQ-019 Reset mid-frame SHALL discard the frame; no partial output byte is held valid after reset.

Verification
REQ-020 Dest 02:00:00:00:00:01, src 02:00:00:00:00:02, type 0x0800, 50-byte payload 0x00..0x31, m_axis_tready=1 -> 64 bytes, header order exact, tlast only on byte 63, tuser 0.
REQ-021 Same header, type 0x0806, 28-byte payload with tuser=1 on last, ENABLE_PADDING=1 -> 60 bytes, bytes 42-59 = 0x00, tlast and tuser=1 on byte 59 only.
REQ-022 Same 28-byte payload with ENABLE_PADDING=0 -> 42 bytes, tlast on byte 41.
REQ-023 Random m_axis_tready (50%) and random payload tvalid gaps on 100 frames -> byte stream identical to tready=1 run; outputs stable while stalled.
REQ-024 Back-to-back headers valid continuously -> second s_eth_hdr_ready pulse only after first frame's tlast byte loaded; no byte gap from first frame's header start beyond backpressure.
REQ-025 Assert rst_n low during payload byte 20 -> m_axis_tvalid=0 immediately, busy=0; next frame after release emitted correctly from byte 0.
